// File: rtl/dragonfang_pkg.sv
// Shared dragonfang types: the execution-result packet and the writeback buffer entry.
package dragonfang_pkg;

    localparam int VWB_DEPTH  = 4;
    localparam int VWB_ADDR_W = 5;
    localparam int VWB_DATA_W = 128;

    typedef struct packed {
        logic                  valid;
        logic [VWB_ADDR_W-1:0] destination;
        logic [VWB_DATA_W-1:0] data;
    } data_packet_t;

    typedef struct packed {
        logic [VWB_ADDR_W-1:0] destination;
        logic [VWB_DATA_W-1:0] data;
    } vwb_entry_t;

endpackage

// File: rtl/vector_writeback_unit_if.sv
// VRF write-port handshake between the writeback unit (master) and the register file (slave).
interface vector_writeback_unit_if
    import dragonfang_pkg::*;
#(
    parameter int ADDR_W = VWB_ADDR_W,
    parameter int DATA_W = VWB_DATA_W
);

    logic              vrf_write_enable;
    logic [ADDR_W-1:0] vrf_write_address;
    logic [DATA_W-1:0] vrf_write_data;
    logic              vrf_write_ready;

    modport master (
        output vrf_write_enable,
        output vrf_write_address,
        output vrf_write_data,
        input  vrf_write_ready
    );

    modport slave (
        input  vrf_write_enable,
        input  vrf_write_address,
        input  vrf_write_data,
        output vrf_write_ready
    );

endinterface

// File: rtl/vector_writeback_fifo.sv
// Generic DEPTH x vwb_entry_t FIFO; head entry is read combinationally from registered storage.
module vector_writeback_fifo
    import dragonfang_pkg::*;
#(
    parameter int DEPTH   = VWB_DEPTH,
    parameter int PTR_W   = $clog2(DEPTH),
    parameter int COUNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  vwb_entry_t         push_entry,
    input  logic               pop,
    output vwb_entry_t         head_entry,
    output logic               full,
    output logic               empty,
    output logic [COUNT_W-1:0] count
);

    vwb_entry_t       storage [DEPTH];
    logic [PTR_W-1:0] write_pointer;
    logic [PTR_W-1:0] read_pointer;
    logic             do_push;
    logic             do_pop;

    assign empty      = (count == '0);
    assign full       = (count == COUNT_W'(DEPTH));
    assign do_pop     = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push    = push && (!full || do_pop);
    assign head_entry = storage[read_pointer];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_pointer <= '0;
            read_pointer  <= '0;
            count         <= '0;
        end else begin
            if (do_push) write_pointer <= write_pointer + 1'b1;
            if (do_pop)  read_pointer  <= read_pointer + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; unwritten slots are never visible because empty gates the outputs.
    always_ff @(posedge clock) begin
        if (do_push) storage[write_pointer] <= push_entry;
    end

endmodule

// File: rtl/vector_writeback_unit.sv
// Buffers execution results and drains them into the VRF write port; regenerates the bypass packet.
// Optional VWB_CUT_THROUGH_EN: an empty buffer forwards a result straight to a ready VRF port.
module vector_writeback_unit
    import dragonfang_pkg::*;
#(
    parameter int DEPTH           = VWB_DEPTH,
    parameter int ADDR_W          = VWB_ADDR_W,
    parameter int DATA_W          = VWB_DATA_W,
    parameter int STALL_THRESHOLD = DEPTH - 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  data_packet_t                   result_port,
    vector_writeback_unit_if.master        vrf,
    output data_packet_t                   bypass_port,
    output logic                           stall_request,
    output logic                           overflow_error
);

    localparam int COUNT_W = $clog2(DEPTH) + 1;

    vwb_entry_t         head_entry;
    vwb_entry_t         commit_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic [COUNT_W-1:0] fifo_count;
    logic               push;
    logic               pop;
    logic               write_valid;
    logic               commit;
    logic               dropped;

    vector_writeback_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry ('{destination: result_port.destination, data: result_port.data}),
        .pop        (pop),
        .head_entry (head_entry),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        commit_entry = head_entry;
        write_valid  = !fifo_empty;
        push         = result_port.valid;
`ifdef VWB_CUT_THROUGH_EN
        if (fifo_empty && result_port.valid) begin
            commit_entry = '{destination: result_port.destination, data: result_port.data};
            write_valid  = 1'b1;
            push         = !vrf.vrf_write_ready;
        end
`endif
    end

    assign pop     = !fifo_empty && vrf.vrf_write_ready;
    assign commit  = write_valid && vrf.vrf_write_ready;
    assign dropped = result_port.valid && fifo_full && !pop;

    assign vrf.vrf_write_enable  = write_valid;
    assign vrf.vrf_write_address = write_valid ? ADDR_W'(commit_entry.destination) : '0;
    assign vrf.vrf_write_data    = write_valid ? DATA_W'(commit_entry.data) : '0;

    assign stall_request = (fifo_count >= COUNT_W'(STALL_THRESHOLD));

    // Bypass is valid only for the cycle after a commit; fields hold afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bypass_port <= '0;
        end else if (commit) begin
            bypass_port <= '{valid: 1'b1, destination: commit_entry.destination, data: commit_entry.data};
        end else begin
            bypass_port.valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)        overflow_error <= 1'b0;
        else if (dropped) overflow_error <= 1'b1;
    end

endmodule

// File: tb/tb_vector_writeback_unit.sv
// Scoreboard bench for vector_writeback_unit: queue-based reference model plus decoupled write monitor.
module tb_vector_writeback_unit;
    import dragonfang_pkg::*;

    localparam int DEPTH = VWB_DEPTH;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    data_packet_t result_port;
    data_packet_t bypass_port;
    logic         stall_request;
    logic         overflow_error;

    vector_writeback_unit_if #(.ADDR_W(VWB_ADDR_W), .DATA_W(VWB_DATA_W)) vrf_if ();

    vector_writeback_unit #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .result_port    (result_port),
        .vrf            (vrf_if),
        .bypass_port    (bypass_port),
        .stall_request  (stall_request),
        .overflow_error (overflow_error)
    );

    always #5 clock = ~clock;

    int           n_checks = 0;
    int           n_fail   = 0;
    vwb_entry_t   model_fifo [$];
    vwb_entry_t   exp_q [$];
    logic         model_ovf = 1'b0;
    data_packet_t exp_bypass = '0;

    task automatic check(input string name, input logic [159:0] actual, input logic [159:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] d, input logic [127:0] dat, input logic rdy);
        result_port.valid       = v;
        result_port.destination = d;
        result_port.data        = dat;
        vrf_if.vrf_write_ready  = rdy;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [127:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference model: occupancy is the queue size; decides acceptance, drops and expected flags.
    always @(negedge clock) begin
        logic ct;
        logic do_pop;
        vwb_entry_t e;
        if (reset) begin
            model_fifo.delete();
            exp_q.delete();
            model_ovf = 1'b0;
            check("reset_enable", 160'(vrf_if.vrf_write_enable), 160'(0));
            check("reset_stall", 160'(stall_request), 160'(0));
            check("reset_overflow", 160'(overflow_error), 160'(0));
        end else begin
            ct = 1'b0;
`ifdef VWB_CUT_THROUGH_EN
            ct = (model_fifo.size() == 0) && result_port.valid;
`endif
            check("enable", 160'(vrf_if.vrf_write_enable), 160'((model_fifo.size() != 0) || ct));
            check("stall_request", 160'(stall_request), 160'(model_fifo.size() >= DEPTH - 1));
            check("overflow_error", 160'(overflow_error), 160'(model_ovf));
            do_pop = (model_fifo.size() != 0) && vrf_if.vrf_write_ready;
            e = '{destination: result_port.destination, data: result_port.data};
            if (result_port.valid) begin
                if (ct && vrf_if.vrf_write_ready) begin
                    exp_q.push_back(e);
                end else if (model_fifo.size() < DEPTH || do_pop) begin
                    model_fifo.push_back(e);
                    exp_q.push_back(e);
                end else begin
                    model_ovf = 1'b1;
                end
            end
            if (do_pop) void'(model_fifo.pop_front());
        end
    end

    // Monitor: consumes expected writes whenever the DUT commits, and tracks the bypass register.
    always @(negedge clock) begin
        vwb_entry_t e;
        #1;
        if (reset) begin
            exp_bypass = '0;
            check("reset_bypass", 160'(bypass_port), 160'(exp_bypass));
        end else begin
            check("bypass_port", 160'(bypass_port), 160'(exp_bypass));
            if (vrf_if.vrf_write_enable && vrf_if.vrf_write_ready) begin
                check("write_expected", 160'(exp_q.size() != 0), 160'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("write_address", 160'(vrf_if.vrf_write_address), 160'(e.destination));
                    check("write_data", 160'(vrf_if.vrf_write_data), 160'(e.data));
                    exp_bypass = '{valid: 1'b1, destination: e.destination, data: e.data};
                end else begin
                    exp_bypass.valid = 1'b0;
                end
            end else begin
                if (!vrf_if.vrf_write_enable) begin
                    check("idle_address", 160'(vrf_if.vrf_write_address), 160'(0));
                    check("idle_data", 160'(vrf_if.vrf_write_data), 160'(0));
                end
                exp_bypass.valid = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        result_port            = '0;
        vrf_if.vrf_write_ready = 1'b0;
        reset                  = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Single result through an idle unit.
        drive(1'b1, 5'd3, {16{8'hA5}}, 1'b1);
        repeat (3) drive(1'b0, 5'd0, '0, 1'b1);

        // Backpressure: fill under ready=0, then drain in order.
        for (int i = 1; i <= 4; i++) drive(1'b1, 5'(i), rand_data(), 1'b0);
        repeat (2) drive(1'b0, 5'd0, '0, 1'b0);
        repeat (6) drive(1'b0, 5'd0, '0, 1'b1);

        // Full with simultaneous push and pop; wraps the pointers.
        for (int i = 1; i <= 4; i++) drive(1'b1, 5'(i), rand_data(), 1'b0);
        drive(1'b1, 5'd7, rand_data(), 1'b1);
        repeat (6) drive(1'b0, 5'd0, '0, 1'b1);

        // Overflow: push into a full buffer with no pop.
        for (int i = 1; i <= 4; i++) drive(1'b1, 5'(i), rand_data(), 1'b0);
        drive(1'b1, 5'd9, rand_data(), 1'b0);
        drive(1'b0, 5'd0, '0, 1'b0);
        repeat (6) drive(1'b0, 5'd0, '0, 1'b1);

        // Reset in the middle of a drain.
        for (int i = 1; i <= 3; i++) drive(1'b1, 5'(i + 16), rand_data(), 1'b0);
        result_port.valid      = 1'b0;
        vrf_if.vrf_write_ready = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_enable", 160'(vrf_if.vrf_write_enable), 160'(0));
        check("async_reset_bypass", 160'(bypass_port), 160'(0));
        check("async_reset_overflow", 160'(overflow_error), 160'(0));
        @(negedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(1'b1, 5'd12, rand_data(), 1'b1);
        repeat (3) drive(1'b0, 5'd0, '0, 1'b1);

        // Empty buffer with ready high, then with ready low.
        drive(1'b1, 5'd5, rand_data(), 1'b1);
        drive(1'b0, 5'd0, '0, 1'b1);
        drive(1'b1, 5'd5, rand_data(), 1'b0);
        drive(1'b0, 5'd0, '0, 1'b0);
        repeat (3) drive(1'b0, 5'd0, '0, 1'b1);

        // Randomized traffic.
        repeat (400) drive(1'($urandom_range(0, 1)), 5'($urandom()), rand_data(), ($urandom_range(0, 9) < 6));
        repeat (8) drive(1'b0, 5'd0, '0, 1'b1);

        check("drain_complete", 160'(exp_q.size()), 160'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_writeback_unit.md
Name: vector_writeback_unit

Overview:
- Sits directly downstream of the vector execution stage. Consumes its registered data_packet_t results.
- Buffers results in a small FIFO and drains them into the vector register file (VRF) write port over a valid/ready handshake.
- Regenerates the bypass data_packet_t that feeds back into the execution stage's bypass input.
- Raises a stall request toward issue before the buffer can overflow, because the execution stage has no backpressure.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ADDR_W, 5, VRF register index width (32 vector registers).
- DATA_W, 128, result data width (VLEN).
- STALL_THRESHOLD, DEPTH-1, occupancy at or above which stall_request asserts.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- result_port  input  data_packet_t  execution result; fields used: valid, destination (ADDR_W), data (DATA_W).
- vrf_write_enable  output  1  head entry is presented to the VRF.
- vrf_write_address  output  ADDR_W  destination register of the head entry.
- vrf_write_data  output  DATA_W  data of the head entry.
- vrf_write_ready  input  1  VRF accepts the write this cycle (port arbitration).
- bypass_port  output  data_packet_t  last committed result, to the execution stage's bypass input.
- stall_request  output  1  occupancy >= STALL_THRESHOLD.
- overflow_error  output  1  sticky; a result was dropped.

Behaviour:
- Reset: one clock, asynchronous, active-high; the polarity and synchronicity are fixed. Asserting reset at any time, including mid-drain, empties the FIFO. On reset: count=0, read/write pointers=0, bypass_port='0, overflow_error=0, stall_request=0, vrf_write_enable=0. Address and data outputs are don't-care while enable=0 and are driven to 0.
- Push: occurs when result_port.valid=1 and (count<DEPTH or pop this cycle). The entry is written at the write pointer, and the pointer wraps modulo DEPTH.
- Pop: occurs when vrf_write_enable && vrf_write_ready. The read pointer advances and wraps modulo DEPTH.
- vrf_write_enable = (count != 0). Address and data come combinationally from the head-entry storage, which is registered.
- Handshake: the head entry and enable must hold stable while ready=0. No write is lost or duplicated.
- Latency: a pushed result reaches vrf_write_enable on the cycle after the push (1 cycle minimum). Results commit in arrival order.
- Simultaneous push and pop: count is unchanged. This is legal when full (the freed slot is reused) and when count=1.
- Push while full with no pop: the result is dropped, the FIFO is unchanged, and overflow_error sets and holds until reset.
- Pop while empty: impossible, because enable=0.
- bypass_port is a register. On a pop cycle it loads {valid=1, destination, data} of the popped entry; on any other cycle valid clears to 0 and the other fields hold their last value. Bypass is therefore valid for exactly the one cycle after the VRF commit.
- stall_request is combinational from the registered count.
- The count is ADDR-independent, has width clog2(DEPTH)+1, and saturates only at DEPTH by construction.

Optional Feature:
- VWB_CUT_THROUGH_EN defined: when count=0, result_port.valid=1 and vrf_write_ready=1, the result drives the VRF write outputs in the same cycle and is not pushed, giving 0-cycle latency. bypass_port loads it as for a pop. If count=0 and ready=0, the result is pushed normally. vrf_write_enable = (count!=0) || (count==0 && result_port.valid).
- Undefined: every result passes through the FIFO with 1-cycle minimum latency, as described above.

Decomposition:
- dragonfang_pkg: VWB_DEPTH constant and vwb_entry_t typedef {destination, data}.
- data_packet_t stays in its existing package and is reused unchanged.
- One sub-module: vector_writeback_fifo. It is a generic DEPTH x vwb_entry_t FIFO with push, pop, full, empty and count.
- vector_writeback_unit adds the handshake, bypass register, stall, overflow and cut-through logic around it.

Test Plan:
- Single result: reset, then result {valid=1, destination=3, data=0xA5..A5} with ready=1. Expect VRF write addr=3 on the next cycle, bypass valid with addr 3 one cycle later, and count back to 0.
- Backpressure: push 4 results (dest 1..4) with ready=0. Expect stall_request=1 at count 3, enable held with addr=1 stable. Then ready=1: writes 1,2,3,4 in order on consecutive cycles.
- Overflow: with the FIFO full and ready=0, push dest=9. Expect the result dropped, overflow_error=1 sticky, and the drain yields only dest 1..4.
- Full simultaneous push/pop: with the FIFO full and ready=1, push dest=7. Expect count to stay 4, no overflow, and 7 written after the existing four. Pointer wrap is checked.
- Reset mid-drain: assert reset with 3 entries queued. Expect enable=0 immediately, bypass_port='0, overflow_error=0; after release the first new push is written correctly.
- VWB_CUT_THROUGH_EN build: with the FIFO empty and ready=1, push dest=5. Expect the VRF write of 5 in the same cycle and count stays 0; with ready=0, expect the normal 1-cycle path.
